phase_burst_controller: RTL and testbench
=========================================

Name: phase_burst_controller

Overview:
Sequencing controller for the phase accumulator in the sin/cos generator. It drives the accumulator's enable and offset inputs and observes its angle/valid outputs. It counts completed periods (angle wrap-arounds) and supports continuous output or a burst of N whole periods. Stops are graceful at a period boundary or immediate on abort.

Parameters:
CNT_W, 16, width of burst length and period counter
ANGLE_W, 24, accumulator angle/offset width (matches accumulator)

Ports:
i_clk  in  1  system clock
i_arst_n  in  1  asynchronous active-low reset
i_start  in  1  start request pulse, honoured only in IDLE
i_stop  in  1  graceful stop request: finish current period, then stop
i_abort  in  1  immediate stop, no done pulse
i_mode  in  1  0 = continuous, 1 = burst
i_burst_len  in  CNT_W  periods per burst (burst mode)
i_phase_offset  in  ANGLE_W  start phase, latched on accepted start
i_angle  in  ANGLE_W  accumulator angle output
i_angle_valid  in  1  accumulator valid output
o_acc_enable  out  1  to accumulator i_enable
o_acc_offset  out  ANGLE_W  to accumulator i_offset
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse on normal completion (burst end or graceful stop)
o_period_cnt  out  CNT_W  completed periods since last start, saturating

Behaviour:
- One clock; reset is asynchronous and active-low on i_arst_n. Reset values: state IDLE; all outputs 0; latched offset 0; prev-angle register 0, prev-valid flag 0.
- All outputs are registered.
- States: IDLE, RUN, STOPPING, DONE.
- IDLE -> RUN when i_start=1, i_stop=0, i_abort=0, and (i_mode=0 or i_burst_len!=0).
  - Same edge: latch i_phase_offset into o_acc_offset, latch i_mode and i_burst_len, clear o_period_cnt and prev-valid flag.
  - o_acc_enable is 1 from the following cycle.
  - Start with burst_len=0, or start together with stop/abort: ignored, remain IDLE.
- Accumulator timing, informative: the accumulator registers enable, so the first i_angle_valid arrives 2 cycles after o_acc_enable rises, with i_angle = latched offset.
- Wrap detection (RUN and STOPPING):
  - wrap = i_angle_valid & prev_valid & (i_angle < prev_angle), unsigned compare.
  - prev_angle/prev_valid update every cycle from i_angle/i_angle_valid.
  - Step size is always < 2^(ANGLE_W-1), so one wrap per period.
- On wrap, o_period_cnt increments, saturating at all-ones. In burst mode o_period_cnt is always <= burst_len.
- RUN -> DONE when i_mode=1 and a wrap brings the count to burst_len.
- RUN -> STOPPING on i_stop (either mode). STOPPING -> DONE on the next wrap, which is counted.
- Stop in the same cycle as a wrap: that wrap is counted and the transition goes to DONE directly.
- i_abort in RUN or STOPPING -> IDLE next edge. o_acc_enable drops, no o_done, o_period_cnt holds its value. Abort has priority over wrap and stop.
- DONE: o_acc_enable=0, o_done=1 for exactly one cycle, then IDLE. o_period_cnt holds until the next accepted start.
- o_acc_enable deasserts on the edge after the terminating wrap. The accumulator may emit one or two further valid samples; these are ignored (not counted) because the state is no longer RUN/STOPPING.
- i_start while busy is ignored. o_acc_offset is stable for the whole run.
- Reset mid-operation: immediate return to reset values, no done pulse.

Decomposition:
- Shared package/header (include-guarded): state encoding localparams (IDLE=2'd0, RUN=2'd1, STOPPING=2'd2, DONE=2'd3), default CNT_W/ANGLE_W.
- One sub-module, phase_wrap_detector: holds prev_angle/prev_valid and outputs a combinational wrap flag. It has a clear input, driven on accepted start.

Test Plan:
- Reset: assert i_arst_n=0 mid-clock -> all outputs 0 immediately. Release -> IDLE, o_busy=0.
- Burst, accumulator stub adding 0x400000 per valid cycle: i_mode=1, i_burst_len=3, i_phase_offset=0x100000, pulse i_start -> o_acc_enable=1 next cycle, first angle 0x100000. Each wrap increments o_period_cnt; after the 3rd wrap o_done pulses once, o_period_cnt=3, o_acc_enable=0.
- Continuous with graceful stop: i_mode=0, start, pulse i_stop after 5 wraps -> stays high through the next wrap, then o_done, o_period_cnt=6. Later samples not counted.
- Abort: i_abort in RUN after 2 wraps -> o_acc_enable and o_busy 0 next edge, o_done never asserts, o_period_cnt=2.
- Rejected starts: i_mode=1, i_burst_len=0, i_start -> stays IDLE. i_start with i_stop in IDLE -> stays IDLE. i_start during RUN with a new offset -> o_acc_offset unchanged.
- Edge cases: i_stop coincident with a wrap -> DONE directly with that wrap counted. Offset 0xFFFFF0 -> first sample treated as non-wrap (prev_valid=0), wrap at 0xFFFFF0->0x3FFFF0 counted. Reset asserted in STOPPING -> IDLE, no done.

Source files
------------

// File: rtl/phase_burst_controller_pkg.sv
// Shared types and defaults for the phase accumulator burst sequencer.
`ifndef PHASE_BURST_CONTROLLER_PKG_SV
`define PHASE_BURST_CONTROLLER_PKG_SV
package phase_burst_controller_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_ANGLE_W = 24;

    localparam logic [1:0] ENC_IDLE     = 2'd0;
    localparam logic [1:0] ENC_RUN      = 2'd1;
    localparam logic [1:0] ENC_STOPPING = 2'd2;
    localparam logic [1:0] ENC_DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_RUN      = ENC_RUN,
        ST_STOPPING = ENC_STOPPING,
        ST_DONE     = ENC_DONE
    } state_t;

endpackage
`endif

// File: rtl/phase_burst_controller_wrap.sv
// Detects accumulator angle wrap-around by comparing against the previous valid sample.
module phase_wrap_detector
    import phase_burst_controller_pkg::*;
#(
    parameter int ANGLE_W = DEF_ANGLE_W
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_clear,
    input  logic [ANGLE_W-1:0] i_angle,
    input  logic               i_angle_valid,
    output logic               o_wrap
);

    logic [ANGLE_W-1:0] prev_angle;
    logic               prev_valid;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            prev_angle <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_angle <= i_angle;
            prev_valid <= i_angle_valid & ~i_clear;
        end
    end

    // Step is below half scale, so any decrease between valid samples is a wrap.
    assign o_wrap = i_angle_valid & prev_valid & (i_angle < prev_angle);

endmodule

// File: rtl/phase_burst_controller.sv
// Sequences the phase accumulator: continuous or N-period bursts, graceful stop, abort.
module phase_burst_controller
    import phase_burst_controller_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ANGLE_W = DEF_ANGLE_W
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_abort,
    input  logic               i_mode,
    input  logic [CNT_W-1:0]   i_burst_len,
    input  logic [ANGLE_W-1:0] i_phase_offset,
    input  logic [ANGLE_W-1:0] i_angle,
    input  logic               i_angle_valid,
    output logic               o_acc_enable,
    output logic [ANGLE_W-1:0] o_acc_offset,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_period_cnt
);

    // state    | meaning
    // IDLE     | waiting for an accepted start
    // RUN      | accumulator enabled, counting periods
    // STOPPING | stop requested, finishing the current period
    // DONE     | one-cycle completion pulse

    state_t             state_q, state_d;
    logic               mode_q;
    logic [CNT_W-1:0]   burst_len_q;
    logic               start_ok;
    logic               active;
    logic               wrap;
    logic               count_en;
    logic [CNT_W-1:0]   cnt_inc;

    phase_wrap_detector #(
        .ANGLE_W (ANGLE_W)
    ) u_wrap (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_clear       (start_ok),
        .i_angle       (i_angle),
        .i_angle_valid (i_angle_valid),
        .o_wrap        (wrap)
    );

    assign start_ok = (state_q == ST_IDLE) & i_start & ~i_stop & ~i_abort
                    & (~i_mode | (i_burst_len != '0));
    assign active   = (state_q == ST_RUN) | (state_q == ST_STOPPING);
    assign count_en = active & wrap & ~i_abort;
    assign cnt_inc  = (&o_period_cnt) ? o_period_cnt : o_period_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_abort)
                    state_d = ST_IDLE;
                else if (wrap && (i_stop || (mode_q && cnt_inc == burst_len_q)))
                    state_d = ST_DONE;
                else if (i_stop)
                    state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (i_abort)
                    state_d = ST_IDLE;
                else if (wrap)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_acc_enable <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_acc_offset <= '0;
            o_period_cnt <= '0;
            mode_q       <= 1'b0;
            burst_len_q  <= '0;
        end else begin
            o_acc_enable <= (state_d == ST_RUN) || (state_d == ST_STOPPING);
            o_busy       <= (state_d != ST_IDLE);
            o_done       <= (state_d == ST_DONE);
            if (start_ok) begin
                o_acc_offset <= i_phase_offset;
                mode_q       <= i_mode;
                burst_len_q  <= i_burst_len;
                o_period_cnt <= '0;
            end else if (count_en) begin
                o_period_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_phase_burst_controller.sv
// Self-checking bench for phase_burst_controller with a behavioural accumulator stub.
module tb_phase_burst_controller;
    import phase_burst_controller_pkg::*;

    localparam int CNT_W   = 16;
    localparam int ANGLE_W = 24;
    localparam logic [ANGLE_W-1:0] STEP = 24'h400000;

    logic               i_clk;
    logic               i_arst_n;
    logic               i_start, i_stop, i_abort, i_mode;
    logic [CNT_W-1:0]   i_burst_len;
    logic [ANGLE_W-1:0] i_phase_offset;
    logic [ANGLE_W-1:0] i_angle;
    logic               i_angle_valid;
    logic               o_acc_enable;
    logic [ANGLE_W-1:0] o_acc_offset;
    logic               o_busy, o_done;
    logic [CNT_W-1:0]   o_period_cnt;

    phase_burst_controller #(.CNT_W(CNT_W), .ANGLE_W(ANGLE_W)) dut (
        .i_clk          (i_clk),
        .i_arst_n       (i_arst_n),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_abort        (i_abort),
        .i_mode         (i_mode),
        .i_burst_len    (i_burst_len),
        .i_phase_offset (i_phase_offset),
        .i_angle        (i_angle),
        .i_angle_valid  (i_angle_valid),
        .o_acc_enable   (o_acc_enable),
        .o_acc_offset   (o_acc_offset),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_period_cnt   (o_period_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Accumulator stub: registers enable, first valid sample is the offset.
    logic en_q;
    always @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            en_q          <= 1'b0;
            i_angle_valid <= 1'b0;
            i_angle       <= '0;
        end else begin
            en_q <= o_acc_enable;
            if (en_q) begin
                i_angle_valid <= 1'b1;
                i_angle       <= i_angle_valid ? i_angle + STEP : o_acc_offset;
            end else begin
                i_angle_valid <= 1'b0;
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        string nm;
        int    cnt;
        int    dones;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic               start, stop, abort, mode;
        logic [CNT_W-1:0]   len;
        logic [ANGLE_W-1:0] off;
        logic               accept;
    } vec_t;
    vec_t vecs[6];

    task automatic idle_inputs();
        i_start = 0; i_stop = 0; i_abort = 0;
    endtask

    task automatic run_scn(input string nm, input logic mode, input int len,
                           input logic [ANGLE_W-1:0] off, input int stop_at,
                           input int abort_at, input int exp_cnt, input int exp_done);
        exp_t e;
        int   dones = 0;
        bit   stop_sent = 0, abort_sent = 0, finished = 0;
        int   abort_cyc = 0;
        int   cyc;
        e.nm = nm; e.cnt = exp_cnt; e.dones = exp_done;
        sb_q.push_back(e);
        @(negedge i_clk);
        i_start = 1; i_mode = mode; i_burst_len = CNT_W'(len); i_phase_offset = off;
        @(negedge i_clk);
        idle_inputs();
        check({nm, "_en"}, o_acc_enable, 1);
        check({nm, "_off"}, o_acc_offset, off);
        for (cyc = 0; cyc < 600; cyc++) begin
            if (o_done) begin
                dones++;
                check({nm, "_done_en"}, o_acc_enable, 0);
            end
            if (!o_busy) begin
                finished = 1;
                break;
            end
            i_stop = 0; i_abort = 0;
            if (stop_at != 0 && !stop_sent && o_period_cnt == CNT_W'(stop_at)) begin
                i_stop = 1; stop_sent = 1;
            end
            if (abort_at != 0 && !abort_sent && o_period_cnt == CNT_W'(abort_at)) begin
                i_abort = 1; abort_sent = 1; abort_cyc = cyc;
            end
            @(negedge i_clk);
        end
        idle_inputs();
        if (!finished) begin
            n_total++;
            $display("FAIL %s_timeout: still busy after 600 cycles, expected idle", nm);
        end
        if (abort_sent) check({nm, "_abort_lat"}, cyc - abort_cyc, 1);
        e = sb_q.pop_front();
        check({e.nm, "_cnt"}, o_period_cnt, e.cnt);
        check({e.nm, "_dones"}, dones, e.dones);
        repeat (4) @(negedge i_clk);
        check({e.nm, "_late_cnt"}, o_period_cnt, e.cnt);
    endtask

    initial begin
        logic [ANGLE_W-1:0] exp_off;
        logic [ANGLE_W-1:0] last_a;
        logic               last_v, wrap_now;
        int                 dones;
        bit                 hit;

        vecs[0] = '{start:1, stop:0, abort:0, mode:1, len:0, off:24'h123456, accept:0};
        vecs[1] = '{start:1, stop:1, abort:0, mode:0, len:3, off:24'h111111, accept:0};
        vecs[2] = '{start:1, stop:0, abort:1, mode:1, len:2, off:24'h333333, accept:0};
        vecs[3] = '{start:0, stop:0, abort:0, mode:0, len:1, off:24'h444444, accept:0};
        vecs[4] = '{start:1, stop:0, abort:0, mode:0, len:0, off:24'h0ABCDE, accept:1};
        vecs[5] = '{start:1, stop:0, abort:0, mode:1, len:5, off:24'h222222, accept:1};

        idle_inputs();
        i_mode = 0; i_burst_len = '0; i_phase_offset = '0;
        i_arst_n = 1;
        #12 i_arst_n = 0;
        #1;
        check("rst_en", o_acc_enable, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cnt", o_period_cnt, 0);
        check("rst_off", o_acc_offset, 0);
        @(negedge i_clk);
        i_arst_n = 1;
        repeat (2) @(negedge i_clk);
        check("post_rst_busy", o_busy, 0);

        exp_off = '0;
        for (int i = 0; i < 6; i++) begin
            i_start = vecs[i].start; i_stop = vecs[i].stop; i_abort = vecs[i].abort;
            i_mode = vecs[i].mode; i_burst_len = vecs[i].len; i_phase_offset = vecs[i].off;
            @(negedge i_clk);
            idle_inputs();
            if (vecs[i].accept) exp_off = vecs[i].off;
            check($sformatf("vec%0d_busy", i), o_busy, vecs[i].accept);
            check($sformatf("vec%0d_en", i), o_acc_enable, vecs[i].accept);
            check($sformatf("vec%0d_off", i), o_acc_offset, exp_off);
            if (vecs[i].accept) begin
                check($sformatf("vec%0d_cnt", i), o_period_cnt, 0);
                i_start = 1; i_phase_offset = ~vecs[i].off;
                @(negedge i_clk);
                idle_inputs();
                check($sformatf("vec%0d_busy_start_off", i), o_acc_offset, exp_off);
                i_abort = 1;
                @(negedge i_clk);
                idle_inputs();
                check($sformatf("vec%0d_abort_busy", i), o_busy, 0);
                check($sformatf("vec%0d_abort_en", i), o_acc_enable, 0);
                check($sformatf("vec%0d_abort_done", i), o_done, 0);
            end
            repeat (5) @(negedge i_clk);
        end

        run_scn("burst3",      1, 3, 24'h100000, 0, 0, 3, 1);
        run_scn("cont_stop5",  0, 0, 24'h100000, 5, 0, 6, 1);
        run_scn("cont_abort2", 0, 0, 24'h100000, 0, 2, 2, 0);
        run_scn("off_fffff0",  1, 1, 24'hFFFFF0, 0, 0, 1, 1);
        run_scn("burst4_stop", 1, 4, 24'h200000, 1, 0, 2, 1);

        // Stop driven in the very cycle the second wrap sample is presented.
        @(negedge i_clk);
        i_start = 1; i_mode = 0; i_burst_len = '0; i_phase_offset = '0;
        last_v = 0; last_a = '0; hit = 0;
        @(negedge i_clk);
        idle_inputs();
        for (int c = 0; c < 200; c++) begin
            wrap_now = i_angle_valid && last_v && (i_angle < last_a);
            last_a = i_angle; last_v = i_angle_valid;
            if (wrap_now && o_period_cnt == 1) begin
                i_stop = 1; hit = 1;
                break;
            end
            @(negedge i_clk);
        end
        if (!hit) begin
            n_total++;
            $display("FAIL coinc_timeout: no second wrap seen, expected one");
        end
        @(negedge i_clk);
        idle_inputs();
        check("coinc_done", o_done, 1);
        check("coinc_cnt", o_period_cnt, 2);
        repeat (2) @(negedge i_clk);
        check("coinc_idle", o_busy, 0);
        repeat (4) @(negedge i_clk);

        // Reset while in STOPPING.
        i_start = 1; i_mode = 0; i_phase_offset = 24'h100000;
        @(negedge i_clk);
        idle_inputs();
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_period_cnt == 1) begin hit = 1; break; end
            @(negedge i_clk);
        end
        if (!hit) begin
            n_total++;
            $display("FAIL rststop_timeout: count never reached 1");
        end
        i_stop = 1;
        @(negedge i_clk);
        idle_inputs();
        check("rststop_busy", o_busy, 1);
        #2 i_arst_n = 0;
        #1;
        check("rststop_en", o_acc_enable, 0);
        check("rststop_busy0", o_busy, 0);
        check("rststop_cnt", o_period_cnt, 0);
        check("rststop_off", o_acc_offset, 0);
        @(negedge i_clk);
        i_arst_n = 1;
        dones = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_done) dones++;
        end
        check("rststop_no_done", dones, 0);
        check("rststop_idle", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
